// File: rtl/wb_sram_bridge_pkg.sv
// Shared types for the Wishbone-to-SRAM burst bridge.
// Holds the bridge FSM encoding and the Wishbone CTI/BTE codes it decodes.
package wb_sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_SINGLE = 2'd1,
        RD_BURST  = 2'd2
    } bridge_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_sram_rd_pipe.sv
// Read-valid tracker: one bit per SRAM read in flight, DEPTH clocks long.
// Ports: clk, rstn (async low), push (read issued), flush (drop all), head (data valid now).
module wb_sram_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic flush,
    output logic head
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(push);
        if (flush) begin
            pipe_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign head = pipe_q[DEPTH-1];

endmodule

// File: rtl/wb_sram_burst_bridge.sv
// Wishbone B3 slave to byte-enable SRAM bridge with pipelined linear read bursts.
// Ports: clk, rstn; wb_s_* Wishbone slave side; sram_m_* SRAM client side.
module wb_sram_burst_bridge
    import wb_sram_bridge_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wb_s_cyc,
    input  logic                       wb_s_stb,
    input  logic                       wb_s_we,
    input  logic [WB_ADDR_WIDTH-1:0]   wb_s_adr,
    input  logic [DATA_WIDTH/8-1:0]    wb_s_sel,
    input  logic [DATA_WIDTH-1:0]      wb_s_dat_w,
    input  logic [2:0]                 wb_s_cti,
    input  logic [1:0]                 wb_s_bte,
    output logic [DATA_WIDTH-1:0]      wb_s_dat_r,
    output logic                       wb_s_ack,
    output logic                       wb_s_err,
    output logic                       wb_s_tgd_r,
    output logic [ADDRESS_WIDTH-1:0]   sram_m_addr,
    output logic                       sram_m_read_en,
    output logic                       sram_m_write_en,
    output logic [DATA_WIDTH/8-1:0]    sram_m_byte_en,
    output logic [DATA_WIDTH-1:0]      sram_m_write_data,
    input  logic [DATA_WIDTH-1:0]      sram_m_read_data
);

    localparam int AL = $clog2(DATA_WIDTH / 8);
    localparam logic [WB_ADDR_WIDTH-1:0] WORD_MASK =
        WB_ADDR_WIDTH'(((64'd1 << ADDRESS_WIDTH) - 64'd1) << AL);

    bridge_state_e state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] burst_addr_q, burst_addr_d;
    logic [ADDRESS_WIDTH-1:0] bus_word;
    logic [ADDRESS_WIDTH-1:0] addr_mux;

    logic req, incr, linear;
    logic push, flush, head;
    logic rd_en, wr_en, rd_ack, wr_ack;
    logic unused_adr;

    assign req      = wb_s_cyc & wb_s_stb;
    assign incr     = (wb_s_cti == CTI_INCR);
    assign linear   = (wb_s_bte == BTE_LINEAR);
    assign bus_word = wb_s_adr[ADDRESS_WIDTH+AL-1:AL];

    // Byte-lane and out-of-range address bits carry no meaning here.
    assign unused_adr = ^(wb_s_adr & ~WORD_MASK);

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        addr_mux     = bus_word;
        push         = 1'b0;
        flush        = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        rd_ack       = 1'b0;
        wr_ack       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && wb_s_we) begin
                    wr_en  = 1'b1;
                    wr_ack = 1'b1;
                end else if (req) begin
                    rd_en = 1'b1;
                    push  = 1'b1;
                    if (incr && linear) begin
                        state_d      = RD_BURST;
                        burst_addr_d = bus_word + ADDRESS_WIDTH'(1);
                    end else begin
                        state_d = RD_SINGLE;
                    end
                end
            end
            RD_SINGLE: begin
                // Return to IDLE when the data lands, even if the master
                // walked away meanwhile; it gets re-served from scratch.
                if (head) begin
                    rd_ack  = req & ~wb_s_we;
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                addr_mux = burst_addr_q;
                rd_ack   = head & req & ~wb_s_we;
                // Any break in the burst drops the speculative reads.
                if (!req || wb_s_we || (rd_ack && !incr)) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (incr) begin
                    rd_en        = 1'b1;
                    push         = 1'b1;
                    burst_addr_d = burst_addr_q + ADDRESS_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            burst_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
        end
    end

    wb_sram_rd_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_pipe (
        .clk  (clk),
        .rstn (rstn),
        .push (push),
        .flush(flush),
        .head (head)
    );

    // Strobes are gated by reset so a request on the bus is ignored
    // without waiting for a clock edge.
    assign wb_s_ack          = rstn & (wr_ack | rd_ack);
    assign sram_m_read_en    = rstn & rd_en;
    assign sram_m_write_en   = rstn & wr_en;
    assign sram_m_addr       = addr_mux;
    assign sram_m_byte_en    = wb_s_sel;
    assign sram_m_write_data = wb_s_dat_w;
    assign wb_s_dat_r        = sram_m_read_data;
    assign wb_s_err          = 1'b0;
    assign wb_s_tgd_r        = 1'b0;

endmodule
